// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data-memory arbiter for scalar and vector requesters
module dmem_arbiter #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               upg_mode_i,
    input  logic               r0_valid_i,
    output logic               r0_ready_o,
    input  logic               r0_wen_i,
    input  logic [13:0]        r0_adr_i,
    input  logic [31:0]        r0_dat_i,
    output logic               r0_rvalid_o,
    output logic [31:0]        r0_rdat_o,
    input  logic               r1_valid_i,
    output logic               r1_ready_o,
    input  logic               r1_wen_i,
    input  logic [11:0]        r1_adr_i,
    input  logic [127:0]       r1_dat_i,
    output logic               r1_rvalid_o,
    output logic [127:0]       r1_rdat_o,
    output logic [13:0]        mem_adr_o,
    output logic               mem_wen_32_o,
    output logic               mem_wen_128_o,
    output logic [31:0]        mem_dat_32_o,
    output logic [127:0]       mem_dat_128_o,
    input  logic [31:0]        mem_rdat_32_i,
    input  logic [127:0]       mem_rdat_128_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   conflict_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;    // 1: r1 won the last grant
    logic [RD_LAT-1:0]   vld_q, vld_d;      // read token valid per pipeline stage
    logic [RD_LAT-1:0]   id_q, id_d;        // read token owner per stage (1 = r1)
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                grant_en, gnt0, gnt1, rd_issue, busy;

    // Grant decision: only in RUN with the programmer idle; ties go to whoever did not win last
    always_comb begin
        grant_en = rst_n_i && (state_q == ST_RUN) && !upg_mode_i;
        gnt0     = grant_en && r0_valid_i && (!r1_valid_i || last_q);
        gnt1     = grant_en && r1_valid_i && (!r0_valid_i || !last_q);
        rd_issue = (gnt0 && !r0_wen_i) || (gnt1 && !r1_wen_i);
        busy     = |vld_q;
    end

    // Read token pipeline shift and round-robin pointer update
    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = rd_issue;
        id_d[0]  = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    // Ownership FSM: leave RUN when the programmer takes the memory, drain reads, then hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (upg_mode_i) begin
                    state_d = busy ? ST_DRAIN : ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (!upg_mode_i) begin
                    state_d = ST_RUN;
                end else if (!busy) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!upg_mode_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Saturating count of RUN cycles in which both requesters compete
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_RUN) && r0_valid_i && r1_valid_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers; a reset discards every read still in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            last_q  <= 1'b1;
            vld_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory drive in the grant cycle and response steering at pipeline exit
    always_comb begin
        r0_ready_o     = gnt0;
        r1_ready_o     = gnt1;
        mem_adr_o      = gnt0 ? r0_adr_i : (gnt1 ? {2'b00, r1_adr_i} : 14'd0);
        mem_wen_32_o   = gnt0 && r0_wen_i;
        mem_wen_128_o  = gnt1 && r1_wen_i;
        mem_dat_32_o   = gnt0 ? r0_dat_i : 32'd0;
        mem_dat_128_o  = gnt1 ? r1_dat_i : 128'd0;
        r0_rvalid_o    = vld_q[RD_LAT-1] && !id_q[RD_LAT-1];
        r1_rvalid_o    = vld_q[RD_LAT-1] && id_q[RD_LAT-1];
        r0_rdat_o      = r0_rvalid_o ? mem_rdat_32_i : 32'd0;
        r1_rdat_o      = r1_rvalid_o ? mem_rdat_128_i : 128'd0;
        busy_o         = busy;
        conflict_cnt_o = cnt_q;
    end

endmodule
